prio_encoder_q: RTL and testbench
=================================

PRIO_ENCODER_Q -- requirements
Module: prio_encoder_q

Interface
REQ-001 SHALL have parameter N, default 8, meaning request count; legal values are powers of two, 2..64.
REQ-002 SHALL have parameter MODE, default 0, meaning 0 = fixed priority (highest index wins) and 1 = round-robin.
REQ-003 SHALL have local width W = log2(N).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit: cascade enable, which gates new selections.
REQ-007 SHALL have port req, input, N bits: request lines; a rising edge on a bit captures that request.
REQ-008 SHALL have port mask, input, N bits: 1 excludes the bit from selection but does not discard it.
REQ-009 SHALL have port code, output, W bits: registered index of the granted request.
REQ-010 SHALL have port valid, output, 1 bit: code is meaningful.
REQ-011 SHALL have port ready, input, 1 bit: the consumer accepts code when valid=1 and ready=1.
REQ-012 SHALL have port any, output, 1 bit: combinational, equal to en AND OR(pending AND NOT mask).
REQ-013 SHALL have port drop, output, 1 bit: registered one-cycle pulse, set when a rising edge hits an already-pending bit.

Function
REQ-014 SHALL register req into req_q every cycle and define edge = req AND NOT req_q.
REQ-015 SHALL set pending[i] on edge[i]; the set takes effect at the same clock edge.
REQ-016 SHALL clear pending[code] at the clock edge where valid=1 and ready=1 (acceptance).
REQ-017 SHALL, when edge[i] and a clear of bit i occur in the same cycle, leave pending[i]=1; the set wins and drop is not asserted.
REQ-018 SHALL assert drop for exactly one cycle when edge[i]=1 and pending[i]=1 with no clear of bit i in that cycle; multiple such bits produce one pulse.
REQ-019 SHALL define the load opportunity as valid=0, or acceptance.
REQ-020 SHALL, at a load opportunity, compute cand = pending AND NOT mask AND NOT clr, where clr is the one-hot bit being accepted this cycle.
REQ-021 SHALL, at a load opportunity with en=1 and cand nonzero, load code with the selected index and set valid=1; otherwise it SHALL set valid=0 and hold code.
REQ-022 SHALL, while valid=1 and ready=0, hold code and valid stable regardless of req, mask or en changes.
REQ-023 SHALL select in MODE 0 the highest set index of cand.
REQ-024 SHALL select in MODE 1 the first set bit of cand searching upward from pointer ptr, wrapping from N-1 to 0.
REQ-025 SHALL, in MODE 1, set ptr to (code+1) mod N on acceptance; ptr SHALL be unchanged otherwise.
REQ-026 SHALL have latency as follows: a req bit rising before clock edge k gives pending at edge k, and valid=1 with code after edge k+1, given an idle output and no higher-priority candidate.
REQ-027 SHALL support back-to-back grants: with ready held at 1 and multiple candidates, valid SHALL stay 1 and code SHALL change every cycle.
REQ-028 SHALL keep masked pending bits; unmasking makes them eligible at the next load opportunity.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force req_q=0, pending=0, code=0, valid=0, drop=0 and ptr=0.
REQ-030 SHALL treat a req bit held high through reset release as a rising edge on the first clock after release.
REQ-031 SHALL, when reset asserts mid-handshake, lose the outstanding grant with no acceptance recorded.

Verification
REQ-032 SHALL cover: N=8, MODE=0, req 00000000->00100100 with ready=1 -> code=5 then code=2 on consecutive cycles, then valid=0.
REQ-033 SHALL cover: N=8, MODE=1, req=8'hFF pulse with ready=1 -> codes 0,1,2,...,7, then valid=0; ptr wraps to 0.
REQ-034 SHALL cover: grant code=3 with ready=0, then a new edge on bit 7 -> code stays 3 until acceptance, then code=7.
REQ-035 SHALL cover: bit 4 pending and a second rising edge on req[4] before acceptance -> drop=1 for one cycle, and only one grant of 4 occurs.
REQ-036 SHALL cover: mask=8'h80 with pending bits 7 and 1 -> code=1; clearing mask -> code=7 at the next load opportunity.
REQ-037 SHALL cover: en=0 with pending nonzero -> any=0 and valid=0; rst_n low mid-grant -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/prio_encoder_q.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_q
// Purpose  : Queued priority encoder. Rising edges on the request lines are
//            captured into a pending set; one pending, unmasked request at a
//            time is granted through a valid/ready output register. The
//            grant is either fixed priority (highest index) or round-robin.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            en     - enable for new selections
//            req    - request lines (rising edge captures a request)
//            mask   - 1 excludes a pending bit from selection (kept pending)
//            code   - registered index of the granted request
//            valid  - code is meaningful
//            ready  - consumer accepts code when valid & ready
//            any    - en & |(pending & ~mask), combinational
//            drop   - one-cycle pulse: rising edge hit an already-pending bit
// Revision : 1.0 - initial release
// ============================================================================
module prio_encoder_q #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    output logic [$clog2(N)-1:0] code,
    output logic                 valid,
    input  logic                 ready,
    output logic                 any,
    output logic                 drop
);

    localparam int W = $clog2(N);

    logic [N-1:0] r_req_q;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_code;
    logic [W-1:0] r_ptr;
    logic         r_valid;
    logic         r_drop;

    logic [N-1:0] w_edge;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_cand;
    logic [N-1:0] w_pending_nxt;
    logic         w_accept;
    logic         w_load;
    logic         w_found;
    logic [W-1:0] w_sel;
    logic [W-1:0] w_idx;

    assign w_edge   = req & ~r_req_q;
    assign w_accept = r_valid & ready;
    // One-hot of the grant being consumed this cycle.
    assign w_clr    = w_accept ? (N'(1) << r_code) : '0;
    // A new edge wins over a simultaneous clear of the same bit.
    assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;
    assign w_load   = ~r_valid | w_accept;
    // The bit being accepted must not be re-granted in the same cycle.
    assign w_cand   = r_pending & ~mask & ~w_clr;

    // Grant selection
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (MODE == 0) begin
            // Ascending scan: the last hit is the highest index.
            for (int i = 0; i < N; i++) begin
                if (w_cand[i]) begin
                    w_sel   = W'(i);
                    w_found = 1'b1;
                end
            end
        end else begin
            // Upward scan from the pointer; W-bit addition wraps N-1 -> 0.
            for (int i = 0; i < N; i++) begin
                w_idx = r_ptr + W'(i);
                if (!w_found && w_cand[w_idx]) begin
                    w_sel   = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_code    <= '0;
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_req_q   <= req;
            r_pending <= w_pending_nxt;
            r_drop    <= |(w_edge & r_pending & ~w_clr);
            if (w_load) begin
                if (en && w_found) begin
                    r_code  <= w_sel;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end
            if (w_accept) begin
                r_ptr <= r_code + W'(1);
            end
        end
    end

    assign code  = r_code;
    assign valid = r_valid;
    assign drop  = r_drop;
    assign any   = en & (|(r_pending & ~mask));

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_encoder_q
// Purpose  : Testbench for prio_encoder_q. Drives a fixed-priority and a
//            round-robin instance with the same stimulus; a behavioural model
//            predicts grants into per-instance queues that a monitor drains
//            on each accepted grant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_encoder_q;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en;
    logic         ready;
    logic [N-1:0] req;
    logic [N-1:0] mask;

    logic [W-1:0] fix_code, rr_code;
    logic         fix_valid, rr_valid;
    logic         fix_any, rr_any;
    logic         fix_drop, rr_drop;

    always #5 clk = ~clk;

    prio_encoder_q #(.N(N), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask),
        .code(fix_code), .valid(fix_valid), .ready(ready),
        .any(fix_any), .drop(fix_drop)
    );

    prio_encoder_q #(.N(N), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask),
        .code(rr_code), .valid(rr_valid), .ready(ready),
        .any(rr_any), .drop(rr_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index 0 = fixed priority, 1 = round-robin
    // ------------------------------------------------------------------
    bit m_pend [2][N];
    bit m_reqq [N];
    bit m_valid[2];
    bit m_drop [2];
    int m_code [2];
    int m_ptr  [2];

    int q_fix[$];
    int q_rr[$];
    int log_fix[$];
    int log_rr[$];
    int exp_q[$];
    int drop_cnt[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) m_pend[m][i] = 1'b0;
            m_valid[m] = 1'b0;
            m_drop[m]  = 1'b0;
            m_code[m]  = 0;
            m_ptr[m]   = 0;
        end
        for (int i = 0; i < N; i++) m_reqq[i] = 1'b0;
        q_fix.delete();
        q_rr.delete();
    endtask

    task automatic model_step(input int m);
        bit acc;
        bit load;
        bit nd;
        bit e;
        bit np[N];
        int clr;
        int sel;
        int idx;
        acc = m_valid[m] && ready;
        clr = acc ? m_code[m] : -1;
        nd  = 1'b0;
        for (int i = 0; i < N; i++) begin
            e = req[i] && !m_reqq[i];
            if (e && m_pend[m][i] && i != clr) nd = 1'b1;
            np[i] = e || (m_pend[m][i] && i != clr);
        end
        load = !m_valid[m] || acc;
        sel  = -1;
        if (load && en) begin
            if (m == 0) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (sel < 0 && m_pend[m][i] && !mask[i] && i != clr) sel = i;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr[m] + k) % N;
                    if (sel < 0 && m_pend[m][idx] && !mask[idx] && idx != clr) sel = idx;
                end
            end
        end
        if (acc) m_ptr[m] = (m_code[m] + 1) % N;
        if (load) begin
            if (sel >= 0) begin
                m_valid[m] = 1'b1;
                m_code[m]  = sel;
                if (m == 0) q_fix.push_back(sel);
                else        q_rr.push_back(sel);
            end else begin
                m_valid[m] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) m_pend[m][i] = np[i];
        m_drop[m] = nd;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
                for (int i = 0; i < N; i++) m_reqq[i] = req[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: per-cycle output checks and scoreboard pop on acceptance
    // ------------------------------------------------------------------
    task automatic mon(input int m, input logic v, input logic [W-1:0] c,
                       input logic d, input logic a);
        string nm;
        bit    exp_any;
        int    expc;
        nm = (m == 0) ? "fix" : "rr";
        exp_any = 1'b0;
        for (int i = 0; i < N; i++) if (m_pend[m][i] && !mask[i]) exp_any = 1'b1;
        exp_any = exp_any && en;
        chk({"valid_", nm}, 32'(v), 32'(m_valid[m]));
        chk({"drop_", nm}, 32'(d), 32'(m_drop[m]));
        chk({"any_", nm}, 32'(a), 32'(exp_any));
        if (m_valid[m]) chk({"code_", nm}, 32'(c), m_code[m]);
        if (d === 1'b1) drop_cnt[m]++;
        if (v === 1'b1 && ready) begin
            if (m == 0) begin
                chk("sb_fix_nonempty", 32'(q_fix.size() > 0), 1);
                if (q_fix.size() > 0) begin
                    expc = q_fix.pop_front();
                    chk("sb_fix_code", 32'(c), expc);
                end
                log_fix.push_back(int'(c));
            end else begin
                chk("sb_rr_nonempty", 32'(q_rr.size() > 0), 1);
                if (q_rr.size() > 0) begin
                    expc = q_rr.pop_front();
                    chk("sb_rr_code", 32'(c), expc);
                end
                log_rr.push_back(int'(c));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon(0, fix_valid, fix_code, fix_drop, fix_any);
                mon(1, rr_valid, rr_code, rr_drop, rr_any);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_log(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
    endtask

    task automatic clear_logs();
        log_fix.delete();
        log_rr.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_fix_valid"}, 32'(fix_valid), 0);
        chk({name, "_fix_code"},  32'(fix_code), 0);
        chk({name, "_fix_drop"},  32'(fix_drop), 0);
        chk({name, "_fix_any"},   32'(fix_any), 0);
        chk({name, "_rr_valid"},  32'(rr_valid), 0);
        chk({name, "_rr_code"},   32'(rr_code), 0);
        chk({name, "_rr_drop"},   32'(rr_drop), 0);
        chk({name, "_rr_any"},    32'(rr_any), 0);
    endtask

    initial begin
        en = 1'b1; ready = 1'b1; req = '0; mask = '0;
        drop_cnt[0] = 0; drop_cnt[1] = 0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Fixed priority: bits 5 and 2 -> 5 then 2
        tick(); clear_logs();
        req = 8'h24;
        repeat (6) tick();
        exp_q = {5, 2};
        check_log("s_two_bits_fix", log_fix, exp_q);
        req = '0;
        repeat (4) tick();

        // All bits from a reset pointer; then wrap check with bits 0 and 3
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        clear_logs();
        req = 8'hFF; tick(); req = '0;
        repeat (10) tick();
        req = 8'h09; tick(); req = '0;
        repeat (5) tick();
        exp_q = {0, 1, 2, 3, 4, 5, 6, 7, 0, 3};
        check_log("s_all_rr", log_rr, exp_q);
        exp_q = {7, 6, 5, 4, 3, 2, 1, 0, 3, 0};
        check_log("s_all_fix", log_fix, exp_q);

        // Stall: code 3 held while bit 7 arrives
        clear_logs();
        ready = 1'b0; req = 8'h08;
        repeat (3) tick();
        chk("stall_fix_valid", 32'(fix_valid), 1);
        chk("stall_fix_code0", 32'(fix_code), 3);
        req = 8'h88;
        repeat (3) tick();
        chk("stall_fix_code1", 32'(fix_code), 3);
        chk("stall_rr_code1", 32'(rr_code), 3);
        ready = 1'b1;
        repeat (4) tick();
        exp_q = {3, 7};
        check_log("s_stall_fix", log_fix, exp_q);
        check_log("s_stall_rr", log_rr, exp_q);
        req = '0;
        repeat (3) tick();

        // Second edge on a pending bit -> one drop, one grant
        clear_logs();
        drop_cnt[0] = 0; drop_cnt[1] = 0;
        ready = 1'b0; req = 8'h10;
        repeat (3) tick();
        req = '0; tick();
        req = 8'h10;
        repeat (3) tick();
        chk("drop_cnt_fix", drop_cnt[0], 1);
        chk("drop_cnt_rr", drop_cnt[1], 1);
        ready = 1'b1;
        repeat (4) tick();
        exp_q = {4};
        check_log("s_drop_fix", log_fix, exp_q);
        check_log("s_drop_rr", log_rr, exp_q);
        req = '0;
        repeat (3) tick();

        // Mask keeps bit 7 pending; unmasking makes it eligible
        clear_logs();
        ready = 1'b0; mask = 8'h80; req = 8'h82;
        repeat (3) tick();
        chk("mask_fix_code", 32'(fix_code), 1);
        chk("mask_rr_code", 32'(rr_code), 1);
        mask = '0; tick();
        chk("mask_fix_hold", 32'(fix_code), 1);
        ready = 1'b1;
        repeat (4) tick();
        exp_q = {1, 7};
        check_log("s_mask_fix", log_fix, exp_q);
        check_log("s_mask_rr", log_rr, exp_q);
        req = '0;
        repeat (3) tick();

        // Disabled: pending requests wait until en returns
        clear_logs();
        en = 1'b0; req = 8'h21;
        repeat (3) tick();
        chk("en0_fix_any", 32'(fix_any), 0);
        chk("en0_fix_valid", 32'(fix_valid), 0);
        chk("en0_rr_valid", 32'(rr_valid), 0);
        en = 1'b1;
        repeat (4) tick();
        exp_q = {5, 0};
        check_log("s_en_fix", log_fix, exp_q);
        exp_q = {0, 5};
        check_log("s_en_rr", log_rr, exp_q);
        req = '0; tick();

        // Reset mid-grant, with a request held high through release
        ready = 1'b0; req = 8'h40;
        repeat (3) tick();
        chk("midrst_fix_valid", 32'(fix_valid), 1);
        chk("midrst_fix_code", 32'(fix_code), 6);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        req = 8'h10;
        tick();
        rst_n = 1'b1;
        clear_logs();
        ready = 1'b1;
        repeat (4) tick();
        exp_q = {4};
        check_log("s_rst_edge_fix", log_fix, exp_q);
        check_log("s_rst_edge_rr", log_rr, exp_q);
        req = '0; tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if (($urandom % 8) == 0) mask = 8'($urandom) & 8'($urandom);
            ready = ($urandom % 4) != 0;
            en    = ($urandom % 16) != 0;
            if (c == 1500) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        // Drain
        en = 1'b1; mask = '0; ready = 1'b1; req = '0;
        repeat (20) tick();
        chk("drain_fix_q", q_fix.size(), 0);
        chk("drain_rr_q", q_rr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
